// File: rtl/key_tick_frontend.sv
// key_tick_frontend
//
// Front end for a stopwatch. Two raw active-low push-buttons are synchronized
// and debounced. KEY[0] produces a one-cycle clear pulse. KEY[1] toggles the
// run level. While running, a prescaler produces a one-cycle 1 Hz tick that
// advances a downstream seconds counter.
//
// Ports:
//   CLOCK_50   in   system clock; all state changes on its rising edge
//   reset      in   asynchronous, active-high reset
//   KEY[1:0]   in   raw buttons, active-low, asynchronous to CLOCK_50
//                   (KEY[0] = clear, KEY[1] = start/stop)
//   tick_1hz   out  one-cycle pulse every TICK_CYCLES cycles while running
//   clr_pulse  out  one-cycle pulse per accepted KEY[0] press
//   run        out  counting enable, toggled per accepted KEY[1] press
//
// Debounce timing: the first edge that samples KEY low is E. The second
// synchronizer flop shows the low at E+1. The FSM enters PRESS_WAIT at E+2
// and HELD at E+2+DB_CYCLES. The press event register rises one edge after
// that, at E+DB_CYCLES+3.
module key_tick_frontend #(
    parameter int TICK_CYCLES = 50000000,
    parameter int DB_CYCLES   = 500000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [1:0] KEY,
    output logic       tick_1hz,
    output logic       clr_pulse,
    output logic       run
);

    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [CW-1:0] DB_LAST    = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_e;

    // Synchronizers. Both flops reset to 1, which is the released level.
    logic [1:0]    sync_a_q;
    logic [1:0]    sync_b_q;

    // Per-key debounce FSM state and stability counters.
    db_state_e     state_q [2];
    db_state_e     state_d [2];
    logic [CW-1:0] cnt_q   [2];
    logic [CW-1:0] cnt_d   [2];

    // held_q[k] is high for one cycle after the PRESS_WAIT->HELD transition.
    // It is the next-state of the press event for each key. Key 0's event is
    // registered as clr_q. Key 1's event is registered directly as the run
    // toggle, so run changes on the same edge the event rises.
    logic [1:0]    held_q;
    logic [1:0]    held_d;
    logic          clr_q;
    logic          clr_d;
    logic          run_q;
    logic          run_d;

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          tick_q;
    logic          tick_d;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync_a_q <= 2'b11;
            sync_b_q <= 2'b11;
            for (int k = 0; k < 2; k++) begin
                state_q[k] <= RELEASED;
                cnt_q[k]   <= '0;
            end
            held_q   <= 2'b00;
            clr_q    <= 1'b0;
            run_q    <= 1'b0;
            presc_q  <= '0;
            tick_q   <= 1'b0;
        end else begin
            sync_a_q <= KEY;
            sync_b_q <= sync_a_q;
            for (int k = 0; k < 2; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
            held_q   <= held_d;
            clr_q    <= clr_d;
            run_q    <= run_d;
            presc_q  <= presc_d;
            tick_q   <= tick_d;
        end
    end

    // Debounce next-state. Press and release are symmetric. Each one needs
    // DB_CYCLES further stable samples after the first sample at the new
    // level. Any sample that disagrees drops back to the previous stable state.
    always_comb begin
        held_d = 2'b00;
        for (int k = 0; k < 2; k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            unique case (state_q[k])
                RELEASED: begin
                    if (!sync_b_q[k]) begin
                        state_d[k] = PRESS_WAIT;
                        cnt_d[k]   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (sync_b_q[k]) begin
                        state_d[k] = RELEASED;
                    end else if (cnt_q[k] == DB_LAST) begin
                        state_d[k] = HELD;
                        held_d[k]  = 1'b1;
                    end else begin
                        cnt_d[k] = cnt_q[k] + 1'b1;
                    end
                end
                HELD: begin
                    if (sync_b_q[k]) begin
                        state_d[k] = RELEASE_WAIT;
                        cnt_d[k]   = '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (!sync_b_q[k]) begin
                        state_d[k] = HELD;
                    end else if (cnt_q[k] == DB_LAST) begin
                        state_d[k] = RELEASED;
                    end else begin
                        cnt_d[k] = cnt_q[k] + 1'b1;
                    end
                end
                default: state_d[k] = RELEASED;
            endcase
        end
    end

    // Press events, run toggle and prescaler. The tick decision uses run_q,
    // which is the pre-toggle value. A clear in progress takes priority over
    // a wrap, so the next tick is a full TICK_CYCLES after the clear.
    always_comb begin
        clr_d   = held_q[0];
        run_d   = run_q ^ held_q[1];
        presc_d = presc_q;
        tick_d  = 1'b0;
        if (clr_q) begin
            presc_d = '0;
        end else if (run_q) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                tick_d  = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    assign tick_1hz  = tick_q;
    assign clr_pulse = clr_q;
    assign run       = run_q;

endmodule

// File: tb/tb_key_tick_frontend.sv
// Bench for key_tick_frontend with TICK_CYCLES=10 and DB_CYCLES=4.
//
// Timing of expected events, with E = first edge sampling KEY low:
//   clr_pulse and run changes are expected at edge E+LAT (LAT = DB+3).
//   A clear forces the prescaler at the next edge.
// The tick schedule is kept as "next expected tick edge" while running, and
// as "held prescaler value" while stopped. It is advanced once per edge.
module tb_key_tick_frontend;

  localparam int TICK = 10;
  localparam int DB   = 4;
  localparam int LAT  = DB + 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] key;
  logic       tick_1hz;
  logic       clr_pulse;
  logic       run;

  key_tick_frontend #(
    .TICK_CYCLES(TICK),
    .DB_CYCLES  (DB)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .KEY      (key),
    .tick_1hz (tick_1hz),
    .clr_pulse(clr_pulse),
    .run      (run)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int          cyc = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  logic        mon_en = 1'b0;
  logic        prev_run = 1'b0;
  logic [31:0] exp_tick_q[$];
  logic [31:0] exp_clr_q[$];
  logic [31:0] exp_run_q[$];
  logic [31:0] toggle_q[$];
  logic [31:0] force_q[$];
  logic        run_exp = 1'b0;
  int          next_tick = 0;
  int          hold_p = 0;
  logic [31:0] exp_v;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic goto_edge(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic gap_wait();
    repeat ($urandom_range(12, 20)) @(negedge clk);
  endtask

  task automatic expect_press(input int k, input int e);
    if (k == 0) begin
      exp_clr_q.push_back(32'(e + LAT));
      force_q.push_back(32'(e + LAT + 1));
    end else begin
      exp_run_q.push_back(32'(e + LAT));
      toggle_q.push_back(32'(e + LAT));
    end
  endtask

  task automatic drain(input string tag);
    check({tag, "_tick_left"}, exp_tick_q.size(), 0);
    check({tag, "_clr_left"}, exp_clr_q.size(), 0);
    check({tag, "_run_left"}, exp_run_q.size(), 0);
  endtask

  // Per-edge schedule update, followed by a sample taken 1 ns after the edge.
  always begin
    @(posedge clk);
    cyc = cyc + 1;
    if (force_q.size() > 0 && force_q[0] == 32'(cyc)) begin
      force_q.delete(0);
      if (run_exp) next_tick = cyc + TICK;
      else hold_p = 0;
    end else if (run_exp && next_tick == cyc) begin
      exp_tick_q.push_back(32'(cyc));
      next_tick = cyc + TICK;
    end
    if (toggle_q.size() > 0 && toggle_q[0] == 32'(cyc)) begin
      toggle_q.delete(0);
      if (run_exp) begin
        hold_p  = TICK - (next_tick - cyc);
        run_exp = 1'b0;
      end else begin
        next_tick = cyc + TICK - hold_p;
        run_exp   = 1'b1;
      end
    end
    #1;
    if (mon_en) begin
      if (tick_1hz === 1'b1) begin
        exp_v = '1;
        if (exp_tick_q.size() > 0) exp_v = exp_tick_q.pop_front();
        check("tick_time", 32'(cyc), exp_v);
      end
      if (clr_pulse === 1'b1) begin
        exp_v = '1;
        if (exp_clr_q.size() > 0) exp_v = exp_clr_q.pop_front();
        check("clr_time", 32'(cyc), exp_v);
      end
      if (run !== prev_run) begin
        exp_v = '1;
        if (exp_run_q.size() > 0) exp_v = exp_run_q.pop_front();
        check("run_toggle_time", 32'(cyc), exp_v);
        prev_run = run;
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int e;
    int t;
    rst = 1'b1;
    key = 2'b11;
    repeat (3) @(negedge clk);
    check("rst_tick", 32'(tick_1hz), 0);
    check("rst_clr", 32'(clr_pulse), 0);
    check("rst_run", 32'(run), 0);
    key[1] = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_key_low_run", 32'(run), 0);
    key[1] = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (8) @(negedge clk);

    // Reset in the middle of PRESS_WAIT, then a full qualification after it.
    key[1] = 1'b0;
    e = cyc + 1;
    goto_edge(e + 4);
    rst = 1'b1;
    #1;
    check("abort_run", 32'(run), 0);
    check("abort_clr", 32'(clr_pulse), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    e = cyc + 1;
    expect_press(1, e);
    goto_edge(e + LAT - 1);
    check("start_run_early", 32'(run), 0);
    goto_edge(e + LAT);
    check("start_run", 32'(run), 1);
    goto_edge(e + 10);
    key[1] = 1'b1;
    goto_edge(e + LAT + 10);
    check("first_tick", 32'(tick_1hz), 1);
    goto_edge(e + LAT + 3 * TICK + 3);
    drain("start");

    // Clear timed to land on the wrap cycle.
    t = next_tick;
    while (t - 9 < cyc) t += TICK;
    goto_edge(t - 9);
    key[0] = 1'b0;
    e = cyc + 1;
    expect_press(0, e);
    goto_edge(t - 1);
    check("clr_at_wrap", 32'(clr_pulse), 1);
    goto_edge(t);
    check("clr_suppress_tick", 32'(tick_1hz), 0);
    goto_edge(t + TICK);
    check("clr_next_tick", 32'(tick_1hz), 1);
    key[0] = 1'b1;
    gap_wait();
    drain("clear");

    // Bouncing clear key, then a clean hold.
    for (int i = 0; i < 5; i++) begin
      key[0] = 1'b0;
      repeat (2) @(negedge clk);
      key[0] = 1'b1;
      repeat (2) @(negedge clk);
    end
    key[0] = 1'b0;
    e = cyc + 1;
    expect_press(0, e);
    goto_edge(e + LAT);
    check("bounce_clr", 32'(clr_pulse), 1);
    goto_edge(e + LAT + 3);
    key[0] = 1'b1;
    gap_wait();
    drain("bounce");

    // Long hold on start/stop: one toggle only, prescaler held while stopped.
    key[1] = 1'b0;
    e = cyc + 1;
    expect_press(1, e);
    repeat (100) @(negedge clk);
    check("long_hold_run", 32'(run), 0);
    key[1] = 1'b1;
    gap_wait();
    drain("hold");
    key[1] = 1'b0;
    e = cyc + 1;
    expect_press(1, e);
    goto_edge(e + 10);
    key[1] = 1'b1;
    check("resume_run", 32'(run), 1);
    goto_edge(next_tick);
    check("resume_tick", 32'(tick_1hz), 1);
    gap_wait();
    key[1] = 1'b0;
    e = cyc + 1;
    expect_press(1, e);
    goto_edge(e + 10);
    key[1] = 1'b1;
    check("stop_run", 32'(run), 0);
    gap_wait();
    drain("resume");

    // Both keys on the same edge while stopped.
    key = 2'b00;
    e = cyc + 1;
    expect_press(0, e);
    expect_press(1, e);
    goto_edge(e + LAT - 1);
    check("both_clr_early", 32'(clr_pulse), 0);
    check("both_run_early", 32'(run), 0);
    goto_edge(e + LAT);
    check("both_clr", 32'(clr_pulse), 1);
    check("both_run", 32'(run), 1);
    goto_edge(e + 12);
    key = 2'b11;
    goto_edge(e + LAT + 1 + TICK);
    check("both_tick", 32'(tick_1hz), 1);
    repeat (35) @(negedge clk);
    drain("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/key_tick_frontend.md
KEY_TICK_FRONTEND -- requirements
Module: key_tick_frontend

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 50000000, meaning CLOCK_50 cycles per one-second tick.
REQ-002 SHALL have parameter DB_CYCLES, default 500000, meaning the number of consecutive stable synchronized samples (10 ms) a key needs to be accepted.
REQ-003 SHALL have port CLOCK_50  input  1  system clock; all state on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port KEY  input  2  raw push-buttons, active-low, asynchronous to CLOCK_50; KEY[0]=clear, KEY[1]=start/stop.
REQ-006 SHALL have port tick_1hz  output  1  one-cycle pulse that advances the downstream seconds counter.
REQ-007 SHALL have port clr_pulse  output  1  one-cycle pulse per accepted KEY[0] press.
REQ-008 SHALL have port run  output  1  level; 1 = counting enabled, toggled per accepted KEY[1] press.

Function
REQ-009 SHALL pass each KEY bit through a 2-flop synchronizer before any other use.
REQ-010 SHALL run an independent 4-state debounce FSM per key: RELEASED, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-011 SHALL move RELEASED->PRESS_WAIT when the synchronized key is 0, clearing that key's stability counter.
REQ-012 SHALL, in PRESS_WAIT, return to RELEASED on a synchronized 1; otherwise increment the counter and enter HELD when it reaches DB_CYCLES-1.
REQ-013 SHALL mirror REQ-011/012 for release: HELD->RELEASE_WAIT on a synchronized 1, and RELEASE_WAIT->RELEASED after DB_CYCLES stable 1 samples; any 0 sample returns to HELD.
REQ-014 SHALL generate exactly one registered press event per key, high for one cycle, in the cycle after the PRESS_WAIT->HELD transition; no event on release.
REQ-015 SHALL fix the total latency at DB_CYCLES+3 rising edges from the first edge that samples KEY low to the edge at which the press event is high, given a clean, bounce-free press.
REQ-016 SHALL drive clr_pulse from the KEY[0] press event.
REQ-017 SHALL toggle run on the cycle the KEY[1] press event is high.
REQ-018 SHALL keep a prescaler of width ceil(log2(TICK_CYCLES)) that increments only while run=1, holds while run=0, and wraps from TICK_CYCLES-1 to 0.
REQ-019 SHALL register tick_1hz high for one cycle on each wrap of the prescaler; the tick period is exactly TICK_CYCLES cycles while run=1.
REQ-020 SHALL, when clr_pulse is high, force the prescaler to 0 and suppress any tick in that cycle, so the first tick after a clear comes a full TICK_CYCLES later; clear wins over a simultaneous wrap.
REQ-021 SHALL evaluate the tick in the same cycle as a run toggle using the pre-toggle run value.
REQ-022 SHALL allow both keys to be processed concurrently; simultaneous press events produce clr_pulse and a run toggle in the same cycle.
REQ-023 SHALL treat a key held indefinitely as a single press; a new event requires passing through RELEASED.
REQ-024 SHALL support TICK_CYCLES>=2 and DB_CYCLES>=1; the counters do not saturate or overflow for these values.

Reset
REQ-025 SHALL, while reset=1, asynchronously force: synchronizer flops=1 (released), both FSMs=RELEASED, stability counters=0, prescaler=0, run=0, tick_1hz=0, clr_pulse=0.
REQ-026 SHALL abort any in-progress debounce when reset asserts mid-press; after release of reset a key still held low requires a full DB_CYCLES qualification.
REQ-027 SHALL begin normal operation on the first rising edge after reset deasserts.

Verification (TICK_CYCLES=10, DB_CYCLES=4)
REQ-028 SHALL pass: reset, then a clean KEY[1] low at edge E0 -> run=1 at E0+7, and tick_1hz pulses at E0+17, E0+27, E0+37.
REQ-029 SHALL pass: KEY[0] bouncing low/high every 2 cycles for 20 cycles and then held low -> exactly one clr_pulse, 7 edges after the final low sample; none during the bounce.
REQ-030 SHALL pass: run=1 and a KEY[0] press timed so clr_pulse coincides with prescaler=9 -> no tick that cycle, and the next tick comes 10 cycles later.
REQ-031 SHALL pass: both keys pressed on the same edge with run=0 -> clr_pulse=1 and run 0->1 in the same cycle.
REQ-032 SHALL pass: reset asserted 2 cycles into PRESS_WAIT with KEY[1] still low -> run=0 and no event; after deassert, run=1 exactly 7 edges later.
REQ-033 SHALL pass: KEY[1] held low for 100 cycles with run=1 -> exactly one toggle; prescaler held at its value while run=0 and resumed after the next press.
